// File: rtl/pwm_pkg.sv
// pwm_pkg: shared types and defaults for the PWM level-limit datapath
package pwm_pkg;
    typedef enum logic [2:0] {IDLE, CHECK, DIV, MULT, DONE} limit_state_t;
    localparam int DEFAULT_BIT_WIDTH = 16;
endpackage

// File: rtl/level_limit_calc_if.sv
// level_limit_calc_if: request/result bundle between a PWM level cell and its limit calculator
interface level_limit_calc_if
    import pwm_pkg::*;
#(
    parameter int BIT_WIDTH = DEFAULT_BIT_WIDTH
);
    logic                 Start;
    logic [BIT_WIDTH-1:0] PWMMaxCount;
    logic [BIT_WIDTH-1:0] Level;
    logic                 Busy;
    logic                 Done;
    logic                 Valid;
    logic                 Error;
    logic [BIT_WIDTH-1:0] LowerLimit;
    logic [BIT_WIDTH-1:0] UpperLimit;
    modport master (
        output Start, PWMMaxCount, Level,
        input  Busy, Done, Valid, Error, LowerLimit, UpperLimit
    );
    modport slave (
        input  Start, PWMMaxCount, Level,
        output Busy, Done, Valid, Error, LowerLimit, UpperLimit
    );
endinterface

// File: rtl/udiv_restoring.sv
// udiv_restoring: fixed BIT_WIDTH-cycle restoring divider; the first quotient bit is resolved
// in the Start cycle, and Done pulses in the cycle the full Quotient is first readable.
module udiv_restoring
    import pwm_pkg::*;
#(
    parameter int BIT_WIDTH = DEFAULT_BIT_WIDTH
) (
    input  logic                 MClk,
    input  logic                 Rst,
    input  logic                 Start,
    input  logic [BIT_WIDTH-1:0] Dividend,
    input  logic [BIT_WIDTH-1:0] Divisor,
    output logic [BIT_WIDTH-1:0] Quotient,
    output logic                 Done
);
    localparam int CW = $clog2(BIT_WIDTH + 1);
    logic [BIT_WIDTH:0]   rem, remIn, shifted, trial;
    logic [BIT_WIDTH-1:0] quoIn, divisorReg, divisorIn;
    logic [CW-1:0]        count;
    logic                 fits;
    always_comb begin
        remIn     = Start ? '0 : rem;
        quoIn     = Start ? Dividend : Quotient;
        divisorIn = Start ? Divisor : divisorReg;
        shifted   = (remIn << 1) | (BIT_WIDTH + 1)'(quoIn[BIT_WIDTH-1]);
        fits      = shifted >= {1'b0, divisorIn};
        trial     = fits ? shifted - {1'b0, divisorIn} : shifted;
    end
    always_ff @(posedge MClk) begin
        if (Rst) begin
            rem        <= '0;
            Quotient   <= '0;
            divisorReg <= '0;
            count      <= '0;
            Done       <= 1'b0;
        end else begin
            Done <= Start ? (BIT_WIDTH == 1) : (count == CW'(1));
            if (Start || count != '0) begin
                rem      <= trial;
                Quotient <= (quoIn << 1) | BIT_WIDTH'(fits);
            end
            if (Start) begin
                count      <= CW'(BIT_WIDTH - 1);
                divisorReg <= Divisor;
            end else if (count != '0) begin
                count <= count - CW'(1);
            end
        end
    end
endmodule

// File: rtl/level_limit_calc.sv
// level_limit_calc: computes a PWM level's carrier band limits Level*Q .. (Level+1)*Q-1,
// Q = PWMMaxCount / LEVEL_COUNT, behind a start/done handshake with sticky Valid/Error.
module level_limit_calc
    import pwm_pkg::*;
#(
    parameter int BIT_WIDTH   = DEFAULT_BIT_WIDTH,
    parameter int LEVEL_COUNT = 2
) (
    input  logic             MClk,
    input  logic             Rst,
    level_limit_calc_if.slave bus
);
    generate
        if (LEVEL_COUNT < 1) begin : gBadLevelCount
            $error("level_limit_calc: LEVEL_COUNT must be >= 1");
        end
    endgenerate
    localparam logic [BIT_WIDTH-1:0] LEVELS = BIT_WIDTH'(LEVEL_COUNT);
    limit_state_t           state, nextState;
    logic [BIT_WIDTH-1:0]   capMax, capLevel, quotient;
    logic [2*BIT_WIDTH-1:0] lowerProd, upperProd;
    logic                   badRequest, divStart, divDone, accept;
    assign accept     = state == IDLE && bus.Start;
    assign badRequest = capLevel >= LEVELS || capMax < LEVELS;
    assign divStart   = state == CHECK && !badRequest;
    assign bus.Busy   = state != IDLE;
    assign bus.Done   = state == DONE;
    udiv_restoring #(.BIT_WIDTH(BIT_WIDTH)) uDiv (
        .MClk     (MClk),
        .Rst      (Rst),
        .Start    (divStart),
        .Dividend (capMax),
        .Divisor  (LEVELS),
        .Quotient (quotient),
        .Done     (divDone)
    );
    always_comb begin
        nextState = state == IDLE  ? (bus.Start ? CHECK : IDLE) :
                    state == CHECK ? (badRequest ? DONE : DIV) :
                    state == DIV   ? (divDone ? MULT : DIV) :
                    state == MULT  ? DONE : IDLE;
        // Full-width products; CHECK guarantees (Level+1)*Q <= PWMMaxCount so truncation is exact.
        lowerProd = {{BIT_WIDTH{1'b0}}, capLevel} * {{BIT_WIDTH{1'b0}}, quotient};
        upperProd = lowerProd + {{BIT_WIDTH{1'b0}}, quotient} - (2 * BIT_WIDTH)'(1);
    end
    always_ff @(posedge MClk) begin
        if (Rst) begin
            state          <= IDLE;
            capMax         <= '0;
            capLevel       <= '0;
            bus.Valid      <= 1'b0;
            bus.Error      <= 1'b0;
            bus.LowerLimit <= '0;
            bus.UpperLimit <= '0;
        end else begin
            state <= nextState;
            if (accept) begin
                capMax    <= bus.PWMMaxCount;
                capLevel  <= bus.Level;
                bus.Valid <= 1'b0;
                bus.Error <= 1'b0;
            end
            if (state == CHECK && badRequest) begin
                bus.Error      <= 1'b1;
                bus.LowerLimit <= '0;
                bus.UpperLimit <= '0;
            end
            if (state == MULT) begin
                bus.LowerLimit <= BIT_WIDTH'(lowerProd);
                bus.UpperLimit <= BIT_WIDTH'(upperProd);
                bus.Valid      <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_level_limit_calc.sv
// tb_level_limit_calc: drives identical requests into LEVEL_COUNT=2 and LEVEL_COUNT=3 instances
// and checks both against an arithmetic reference model plus a hand-computed vector table.
module tb_level_limit_calc;
    localparam int W = 16;
    logic         MClk = 1'b0;
    logic         Rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] maxCount = '0;
    logic [W-1:0] level = '0;
    int           checks = 0;
    int           errors = 0;
    int           prevLo[2] = '{0, 0};
    int           prevUp[2] = '{0, 0};
    logic         dDone[2], dBusy[2], dValid[2], dError[2];
    logic [W-1:0] dLo[2], dUp[2];
    always #5 MClk = ~MClk;
    level_limit_calc_if #(.BIT_WIDTH(W)) bus2 ();
    level_limit_calc_if #(.BIT_WIDTH(W)) bus3 ();
    assign bus2.Start = start;
    assign bus2.PWMMaxCount = maxCount;
    assign bus2.Level = level;
    assign bus3.Start = start;
    assign bus3.PWMMaxCount = maxCount;
    assign bus3.Level = level;
    assign dDone[0] = bus2.Done;
    assign dBusy[0] = bus2.Busy;
    assign dValid[0] = bus2.Valid;
    assign dError[0] = bus2.Error;
    assign dLo[0] = bus2.LowerLimit;
    assign dUp[0] = bus2.UpperLimit;
    assign dDone[1] = bus3.Done;
    assign dBusy[1] = bus3.Busy;
    assign dValid[1] = bus3.Valid;
    assign dError[1] = bus3.Error;
    assign dLo[1] = bus3.LowerLimit;
    assign dUp[1] = bus3.UpperLimit;
    level_limit_calc #(.BIT_WIDTH(W), .LEVEL_COUNT(2)) dut2 (.MClk(MClk), .Rst(Rst), .bus(bus2));
    level_limit_calc #(.BIT_WIDTH(W), .LEVEL_COUNT(3)) dut3 (.MClk(MClk), .Rst(Rst), .bus(bus3));
    function automatic int levelsOf(input int d);
        return d == 0 ? 2 : 3;
    endfunction
    function automatic void model(input int lc, input int m, input int l,
                                  output int lo, output int up, output int err);
        int q;
        err = (l >= lc || m < lc) ? 1 : 0;
        q = m / lc;
        lo = err ? 0 : l * q;
        up = err ? 0 : (l + 1) * q - 1;
    endfunction
    task automatic chk(input string name, input int d, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s dut%0d actual=%0d required=%0d", name, levelsOf(d), act, exp);
        end
    endtask
    task automatic checkIdleZero(input string name);
        for (int d = 0; d < 2; d++) begin
            chk({name, "_busy"}, d, int'(dBusy[d]), 0);
            chk({name, "_done"}, d, int'(dDone[d]), 0);
            chk({name, "_valid"}, d, int'(dValid[d]), 0);
            chk({name, "_error"}, d, int'(dError[d]), 0);
            chk({name, "_lo"}, d, int'(dLo[d]), 0);
            chk({name, "_up"}, d, int'(dUp[d]), 0);
        end
    endtask
    // One request on both instances; outputs return what the LEVEL_COUNT=2 instance produced.
    task automatic request(input int m, input int l, output int lo0, output int up0, output int err0);
        int doneAt[2], lo[2], up[2], er[2], vl[2], bz[2];
        int eLo, eUp, eErr;
        doneAt = '{0, 0};
        @(negedge MClk);
        maxCount = W'(m);
        level = W'(l);
        start = 1'b1;
        @(negedge MClk);
        start = 1'b0;
        maxCount = W'($urandom);
        level = W'($urandom_range(0, 3));
        for (int d = 0; d < 2; d++) begin
            chk("busy_after_accept", d, int'(dBusy[d]), 1);
            chk("valid_cleared", d, int'(dValid[d]), 0);
            chk("error_cleared", d, int'(dError[d]), 0);
            chk("done_not_early", d, int'(dDone[d]), 0);
            chk("lower_held", d, int'(dLo[d]), prevLo[d]);
            chk("upper_held", d, int'(dUp[d]), prevUp[d]);
        end
        for (int n = 1; n <= 30; n++) begin
            if (n > 1) @(negedge MClk);
            for (int d = 0; d < 2; d++) begin
                if (dDone[d] && doneAt[d] != 0) chk("done_single_pulse", d, int'(dDone[d]), 0);
                if (dDone[d] && doneAt[d] == 0) begin
                    doneAt[d] = n;
                    lo[d] = int'(dLo[d]);
                    up[d] = int'(dUp[d]);
                    er[d] = int'(dError[d]);
                    vl[d] = int'(dValid[d]);
                    bz[d] = int'(dBusy[d]);
                end
            end
            if (doneAt[0] != 0 && doneAt[1] != 0) break;
        end
        for (int d = 0; d < 2; d++) begin
            model(levelsOf(d), m, l, eLo, eUp, eErr);
            chk("done_latency", d, doneAt[d], eErr ? 2 : W + 3);
            if (doneAt[d] != 0) begin
                chk("lower_limit", d, lo[d], eLo);
                chk("upper_limit", d, up[d], eUp);
                chk("error_flag", d, er[d], eErr);
                chk("valid_flag", d, vl[d], 1 - eErr);
                chk("busy_in_done", d, bz[d], 1);
            end
            prevLo[d] = eLo;
            prevUp[d] = eUp;
        end
        lo0 = lo[0];
        up0 = up[0];
        err0 = er[0];
    endtask
    typedef struct {
        int m;
        int l;
        int lo;
        int up;
        int err;
    } vec_t;
    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end
    initial begin
        vec_t tbl[10];
        int lo, up, err, em, el, eLo, eUp, eErr, doneCount;
        int qm[$], ql[$];
        // Expected values for LEVEL_COUNT=2, worked by hand.
        tbl[0] = '{1000, 1, 500, 999, 0};
        tbl[1] = '{1000, 0, 0, 499, 0};
        tbl[2] = '{65535, 1, 32767, 65533, 0};
        tbl[3] = '{1000, 2, 0, 0, 1};
        tbl[4] = '{1, 0, 0, 0, 1};
        tbl[5] = '{2, 1, 1, 1, 0};
        tbl[6] = '{3, 0, 0, 0, 0};
        tbl[7] = '{0, 0, 0, 0, 1};
        tbl[8] = '{1000, 0, 0, 499, 0};
        tbl[9] = '{1000, 2, 0, 0, 1};
        repeat (3) @(negedge MClk);
        checkIdleZero("reset");
        Rst = 1'b0;
        foreach (tbl[i]) begin
            request(tbl[i].m, tbl[i].l, lo, up, err);
            chk($sformatf("table%0d_lower", i), 0, lo, tbl[i].lo);
            chk($sformatf("table%0d_upper", i), 0, up, tbl[i].up);
            chk($sformatf("table%0d_error", i), 0, err, tbl[i].err);
        end
        for (int i = 0; i < 40; i++)
            request($urandom_range(0, 3) == 0 ? int'($urandom_range(0, 4)) : int'($urandom_range(0, 65535)),
                    int'($urandom_range(0, 3)), lo, up, err);
        // Start held high back-to-back; inputs scrambled mid-DIV must not disturb results.
        @(negedge MClk);
        maxCount = W'($urandom_range(3, 65535));
        level = W'($urandom_range(0, 1));
        start = 1'b1;
        for (int n = 0; n < 60; n++) begin
            if (n > 0) @(negedge MClk);
            if (n % 20 == 0) begin
                qm.push_back(int'(maxCount));
                ql.push_back(int'(level));
            end
            if (n % 20 == 5) begin
                maxCount = W'($urandom_range(3, 65535));
                level = W'($urandom_range(0, 1));
            end
            if (n % 20 == 19) begin
                em = qm.pop_front();
                el = ql.pop_front();
                for (int d = 0; d < 2; d++) begin
                    model(levelsOf(d), em, el, eLo, eUp, eErr);
                    chk("held_start_done", d, int'(dDone[d]), 1);
                    chk("held_start_lower", d, int'(dLo[d]), eLo);
                    chk("held_start_upper", d, int'(dUp[d]), eUp);
                    chk("held_start_valid", d, int'(dValid[d]), 1);
                    prevLo[d] = eLo;
                    prevUp[d] = eUp;
                end
                if (n == 59) start = 1'b0;
            end else if (n % 20 == 0) begin
                for (int d = 0; d < 2; d++) chk("held_start_no_done", d, int'(dDone[d]), 0);
            end
        end
        // Reset during the fifth DIV cycle aborts without a Done pulse.
        @(negedge MClk);
        maxCount = W'(1000);
        level = W'(1);
        start = 1'b1;
        @(negedge MClk);
        start = 1'b0;
        repeat (5) @(negedge MClk);
        Rst = 1'b1;
        @(negedge MClk);
        checkIdleZero("abort_reset");
        Rst = 1'b0;
        doneCount = 0;
        repeat (25) begin
            @(negedge MClk);
            doneCount += int'(dDone[0]) + int'(dDone[1]);
        end
        chk("abort_no_done", 0, doneCount, 0);
        prevLo = '{0, 0};
        prevUp = '{0, 0};
        request(1000, 1, lo, up, err);
        chk("after_reset_lower", 0, lo, 500);
        chk("after_reset_upper", 0, up, 999);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
